// File: rtl/buf_dat_loop_fsm_pkg.sv
// Shared widths and state encoding for the CONV buffer feature-read loop sequencer.
package buf_dat_loop_fsm_pkg;

  localparam int KW_DEF = 4;
  localparam int CW_DEF = 10;
  localparam int WW_DEF = 10;
  localparam int GW_DEF = 10;
  localparam int HW_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/buf_dat_loop_fsm_if.sv
// Feature-read handshake and loop-boundary strobes toward the stripe controller.
interface buf_dat_loop_fsm_if;

  logic dat_ch_go;
  logic feature_data_rdy;
  logic feature_data_vld;
  logic CHinKyKx_max_now_comb;
  logic Wout_loop_end_comb;

  modport master (
    input  dat_ch_go,
    input  feature_data_rdy,
    output feature_data_vld,
    output CHinKyKx_max_now_comb,
    output Wout_loop_end_comb
  );

  modport slave (
    output dat_ch_go,
    output feature_data_rdy,
    input  feature_data_vld,
    input  CHinKyKx_max_now_comb,
    input  Wout_loop_end_comb
  );

endinterface

// File: rtl/buf_dat_loop_fsm_loop_cnt.sv
// Wrap counter: counts 0..max on en, flags last at max, synchronous clear.
module loop_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/buf_dat_loop_fsm.sv
// Walks Kx->Ky->CHin->Wout->Cout->Hout, one feature-read beat per accepted handshake.
module buf_dat_loop_fsm
  import buf_dat_loop_fsm_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int CW = CW_DEF,
  parameter int WW = WW_DEF,
  parameter int GW = GW_DEF,
  parameter int HW = HW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        cfg_kx,
  input  logic [KW-1:0]        cfg_ky,
  input  logic [CW-1:0]        cfg_chin,
  input  logic [WW-1:0]        cfg_wout,
  input  logic [GW-1:0]        cfg_cout,
  input  logic [HW-1:0]        cfg_hout,
  buf_dat_loop_fsm_if.master   feat,
  output logic [KW-1:0]        kx,
  output logic [KW-1:0]        ky,
  output logic [CW-1:0]        chin,
  output logic [WW-1:0]        wout,
  output logic [GW-1:0]        cout,
  output logic [HW-1:0]        hout,
  output logic                 busy,
  output logic                 done
);

  state_e state, state_nxt;

  logic [KW-1:0] max_kx, max_ky;
  logic [CW-1:0] max_chin;
  logic [WW-1:0] max_wout;
  logic [GW-1:0] max_cout;
  logic [HW-1:0] max_hout;

  logic ld, acc;
  logic last_kx, last_ky, last_chin, last_wout, last_cout, last_hout;
  logic en_ky, en_chin, en_wout, en_cout, en_hout;

  // Terminal counts are held as cfg-1 so mid-layer cfg changes cannot disturb the walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_kx   <= '0;
      max_ky   <= '0;
      max_chin <= '0;
      max_wout <= '0;
      max_cout <= '0;
      max_hout <= '0;
    end else if (ld) begin
      max_kx   <= cfg_kx   - 1'b1;
      max_ky   <= cfg_ky   - 1'b1;
      max_chin <= cfg_chin - 1'b1;
      max_wout <= cfg_wout - 1'b1;
      max_cout <= cfg_cout - 1'b1;
      max_hout <= cfg_hout - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt                  = state;
    ld                         = 1'b0;
    acc                        = 1'b0;
    busy                       = 1'b1;
    done                       = 1'b0;
    feat.feature_data_vld      = 1'b0;
    feat.CHinKyKx_max_now_comb = 1'b0;
    feat.Wout_loop_end_comb    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          ld        = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        feat.feature_data_vld      = feat.dat_ch_go;
        acc                        = feat.dat_ch_go & feat.feature_data_rdy;
        feat.CHinKyKx_max_now_comb = last_kx & last_ky & last_chin;
        feat.Wout_loop_end_comb    = acc & last_kx & last_ky & last_chin & last_wout;
        if (acc & last_kx & last_ky & last_chin & last_wout & last_cout & last_hout)
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign en_ky   = acc     & last_kx;
  assign en_chin = en_ky   & last_ky;
  assign en_wout = en_chin & last_chin;
  assign en_cout = en_wout & last_wout;
  assign en_hout = en_cout & last_cout;

  loop_cnt #(.W(KW)) u_kx   (.clk(clk), .rst_n(rst_n), .en(acc),     .clr(ld), .max(max_kx),   .cnt(kx),   .last(last_kx));
  loop_cnt #(.W(KW)) u_ky   (.clk(clk), .rst_n(rst_n), .en(en_ky),   .clr(ld), .max(max_ky),   .cnt(ky),   .last(last_ky));
  loop_cnt #(.W(CW)) u_chin (.clk(clk), .rst_n(rst_n), .en(en_chin), .clr(ld), .max(max_chin), .cnt(chin), .last(last_chin));
  loop_cnt #(.W(WW)) u_wout (.clk(clk), .rst_n(rst_n), .en(en_wout), .clr(ld), .max(max_wout), .cnt(wout), .last(last_wout));
  loop_cnt #(.W(GW)) u_cout (.clk(clk), .rst_n(rst_n), .en(en_cout), .clr(ld), .max(max_cout), .cnt(cout), .last(last_cout));
  loop_cnt #(.W(HW)) u_hout (.clk(clk), .rst_n(rst_n), .en(en_hout), .clr(ld), .max(max_hout), .cnt(hout), .last(last_hout));

endmodule

// File: tb/tb_buf_dat_loop_fsm.sv
// Scoreboard bench: the expected beat sequence is queued at start and popped on every accept.
module tb_buf_dat_loop_fsm;
  import buf_dat_loop_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] cfg_kx = '0, cfg_ky = '0;
  logic [9:0] cfg_chin = '0, cfg_wout = '0, cfg_cout = '0, cfg_hout = '0;
  logic [3:0] kx, ky;
  logic [9:0] chin, wout, cout, hout;
  logic busy, done;

  buf_dat_loop_fsm_if fd ();

  buf_dat_loop_fsm #(.KW(4), .CW(10), .WW(10), .GW(10), .HW(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_kx(cfg_kx), .cfg_ky(cfg_ky), .cfg_chin(cfg_chin),
    .cfg_wout(cfg_wout), .cfg_cout(cfg_cout), .cfg_hout(cfg_hout),
    .feat(fd.master),
    .kx(kx), .ky(ky), .chin(chin), .wout(wout), .cout(cout), .hout(hout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] kx, ky;
    logic [9:0] chin, wout, cout, hout;
    logic       cmax, wend;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_vld"},  fd.feature_data_vld, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_idx"},  {kx, ky, chin, wout, cout, hout}, 0);
    chk({tag, "_cmax"}, fd.CHinKyKx_max_now_comb, 0);
    chk({tag, "_wend"}, fd.Wout_loop_end_comb, 0);
  endtask

  task automatic run_layer(input int nkx, input int nky, input int nch, input int nwo,
                           input int nco, input int nho, input int rdy_pct,
                           input int gate_at, input int reset_at, input int restart_at,
                           input bit poke_done);
    beat_t b;
    int total, beats, cyc, gate_cnt, n_wend, n_cmax;
    bit gated, restarted, acc, go;
    sb.delete();
    for (int h = 0; h < nho; h++)
      for (int c = 0; c < nco; c++)
        for (int w = 0; w < nwo; w++)
          for (int ch = 0; ch < nch; ch++)
            for (int y = 0; y < nky; y++)
              for (int x = 0; x < nkx; x++) begin
                b.kx   = 4'(x);  b.ky   = 4'(y);
                b.chin = 10'(ch); b.wout = 10'(w);
                b.cout = 10'(c); b.hout = 10'(h);
                b.cmax = (x == nkx-1) && (y == nky-1) && (ch == nch-1);
                b.wend = b.cmax && (w == nwo-1);
                sb.push_back(b);
              end
    total = sb.size();
    beats = 0; cyc = 0; gate_cnt = 0; n_wend = 0; n_cmax = 0;
    gated = 0; restarted = 0;

    @(negedge clk);
    cfg_kx = 4'(nkx); cfg_ky = 4'(nky); cfg_chin = 10'(nch);
    cfg_wout = 10'(nwo); cfg_cout = 10'(nco); cfg_hout = 10'(nho);
    fd.dat_ch_go = 1'b0; fd.feature_data_rdy = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    while (sb.size() > 0 && cyc < 20000) begin
      if (gate_at >= 0 && beats == gate_at && !gated) begin
        gate_cnt = 10;
        gated = 1;
      end
      go = (gate_cnt == 0);
      if (gate_cnt > 0) gate_cnt--;
      fd.dat_ch_go = go;
      fd.feature_data_rdy = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      if (restart_at >= 0 && beats == restart_at && !restarted) begin
        start = 1'b1;
        cfg_kx = 4'd1; cfg_ky = 4'd2; cfg_chin = 10'd1;
        cfg_wout = 10'd1; cfg_cout = 10'd1; cfg_hout = 10'd1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      #1;
      acc = go && fd.feature_data_rdy;
      chk("vld", fd.feature_data_vld, go);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("idx", {kx, ky, chin, wout, cout, hout},
          {sb[0].kx, sb[0].ky, sb[0].chin, sb[0].wout, sb[0].cout, sb[0].hout});
      chk("cmax", fd.CHinKyKx_max_now_comb, sb[0].cmax);
      chk("wend", fd.Wout_loop_end_comb, acc ? sb[0].wend : 1'b0);
      if (acc) begin
        if (fd.Wout_loop_end_comb) n_wend++;
        if (fd.CHinKyKx_max_now_comb) n_cmax++;
        void'(sb.pop_front());
        beats++;
      end
      if (reset_at >= 0 && beats == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        fd.dat_ch_go = 1'b1; fd.feature_data_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          chk("rst_no_done", done, 0);
          chk("rst_stay_idle", busy, 0);
        end
        sb.delete();
        return;
      end
      if (sb.size() > 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (sb.size() > 0) chk("timeout", sb.size(), 0);

    @(negedge clk);
    start = poke_done;
    fd.dat_ch_go = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    @(negedge clk);
    #1;
    chk("stay_idle", busy, 0);
    chk("beats", beats, total);
    chk("wend_count", n_wend, nco * nho);
    chk("cmax_count", n_cmax, total / (nkx * nky * nch));
  endtask

  initial begin
    fd.dat_ch_go = 1'b0;
    fd.feature_data_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    fd.dat_ch_go = 1'b1;
    #1;
    chk("idle_vld_gated", fd.feature_data_vld, 0);

    run_layer(1, 1, 1, 1, 1, 1, 100, -1, -1, -1, 0);
    run_layer(3, 3, 2, 4, 2, 2, 100, -1, -1, -1, 0);
    run_layer(3, 3, 2, 4, 2, 2,  50, -1, -1, -1, 0);
    run_layer(3, 3, 2, 4, 2, 2, 100, 40, -1, -1, 0);
    run_layer(3, 3, 2, 4, 2, 2, 100, -1, 100, -1, 0);
    run_layer(3, 3, 2, 4, 2, 2, 100, -1, -1, -1, 0);
    run_layer(3, 3, 2, 4, 2, 2, 100, -1, -1, 50, 1);
    run_layer(2, 1, 3, 2, 1, 3,  70, 5, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
